// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the multi-cycle divider: FSM encodings, ready flags
// and zero constants used by the divider control and its datapath.
package div_ctrl_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [DEF_WIDTH-1:0]   ZeroWord       = '0;
    localparam logic [2*DEF_WIDTH-1:0] DoubleZeroWord = '0;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the partial remainder left, pull in the
// next dividend bit, trial-subtract the divisor and shift the quotient bit in.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dq_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dq_o
);

    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] diff;
    logic             ge;
    logic             unused_bits;

    // dq holds the not-yet-consumed dividend bits on the left and the quotient
    // bits produced so far on the right; after WIDTH steps it is the quotient.
    assign trial = {rem_i, dq_i[WIDTH-1]};
    assign diff  = {1'b0, trial} - {2'b00, divisor_i};
    assign ge    = ~diff[WIDTH+1];

    // A kept difference is always below the divisor, so its top bit is zero.
    assign rem_o       = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign dq_o        = {dq_i[WIDTH-2:0], ge};
    assign unused_bits = ^{diff[WIDTH], trial[WIDTH]};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed/unsigned divider controller: accepts a request from EX,
// runs one restoring step per cycle and presents {remainder, quotient}.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o,
    output div_state_t         dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Handshake: start_i is held high until the cycle ready_o is seen; ready_o
    // stays high with result_o stable until start_i drops, and annul_i aborts.
    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, dq, dvs;
    logic [WIDTH-1:0] rem_nxt, dq_nxt;
    logic             qneg, rneg;
    logic             op1_neg, op2_neg;
    logic [WIDTH-1:0] op1_abs, op2_abs;

    assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    assign op1_abs = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    assign op2_abs = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

    assign stallreq_o = start_i & ~ready_o & ~annul_i;
    assign dbg_state  = state;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem),
        .dq_i      (dq),
        .divisor_i (dvs),
        .rem_o     (rem_nxt),
        .dq_o      (dq_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= '0;
            rem      <= WIDTH'(ZeroWord);
            dq       <= WIDTH'(ZeroWord);
            dvs      <= WIDTH'(ZeroWord);
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            result_o <= (2*WIDTH)'(DoubleZeroWord);
            ready_o  <= DivResultNotReady;
        end else begin
            case (state)
                DivFree: begin
                    result_o <= (2*WIDTH)'(DoubleZeroWord);
                    ready_o  <= DivResultNotReady;
                    if (start_i && !annul_i) begin
                        dvs   <= op2_abs;
                        dq    <= op1_abs;
                        rem   <= WIDTH'(ZeroWord);
                        cnt   <= '0;
                        qneg  <= op1_neg ^ op2_neg;
                        rneg  <= op1_neg;
                        state <= (opdata2_i == WIDTH'(ZeroWord)) ? DivByZero : DivOn;
                    end
                end
                DivByZero: begin
                    if (annul_i) begin
                        state <= DivFree;
                    end else begin
                        result_o <= (2*WIDTH)'(DoubleZeroWord);
                        ready_o  <= DivResultReady;
                        state    <= DivEnd;
                    end
                end
                DivOn: begin
                    if (annul_i) begin
                        state <= DivFree;
                        cnt   <= '0;
                    end else begin
                        rem <= rem_nxt;
                        dq  <= dq_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH-1)) begin
                            // Two's-complement sign fix-up; the most negative
                            // quotient wraps onto itself instead of trapping.
                            result_o <= {rneg ? (~rem_nxt + 1'b1) : rem_nxt,
                                         qneg ? (~dq_nxt + 1'b1) : dq_nxt};
                            ready_o  <= DivResultReady;
                            cnt      <= '0;
                            state    <= DivEnd;
                        end
                    end
                end
                DivEnd: begin
                    if (!start_i) begin
                        result_o <= (2*WIDTH)'(DoubleZeroWord);
                        ready_o  <= DivResultNotReady;
                        state    <= DivFree;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: a driver issues divides and pushes hand-computed
// results; an independent monitor pops and checks them when ready_o rises.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           annul = 1'b0;
    logic           sgn = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [2*W-1:0] result;
    logic           ready;
    logic           stall;
    div_state_t     dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int issue_cyc = 0;

    logic [2*W-1:0] exp_q[$];
    int             lat_q[$];
    logic           in_end = 1'b0;
    logic           have_exp = 1'b0;
    logic [2*W-1:0] cur_res = '0;

    div_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .annul_i      (annul),
        .signed_div_i (sgn),
        .opdata1_i    (a),
        .opdata2_i    (b),
        .result_o     (result),
        .ready_o      (ready),
        .stallreq_o   (stall),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (ready) begin
                if (!in_end) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        have_exp = 1'b0;
                        $display("FAIL unexpected_ready: got ready=1 expected no result (t=%0t)", $time);
                    end else begin
                        int lat;
                        cur_res  = exp_q.pop_front();
                        lat      = lat_q.pop_front();
                        have_exp = 1'b1;
                        check("latency", 64'(cyc - issue_cyc), 64'(lat));
                    end
                    in_end = 1'b1;
                end
                if (have_exp) check("result", result, cur_res);
            end else begin
                in_end = 1'b0;
                check("idle_result", result, 64'd0);
            end
        end
    end

    // driver tasks (call right after a posedge)
    task automatic issue(input logic [W-1:0] op1, input logic [W-1:0] op2, input logic s,
                         input logic [2*W-1:0] exp, input int lat);
        a = op1;
        b = op2;
        sgn = s;
        start = 1'b1;
        issue_cyc = cyc;
        exp_q.push_back(exp);
        lat_q.push_back(lat);
    endtask

    task automatic wait_ready(input int bound);
        bit got = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (ready) begin
                got = 1'b1;
                break;
            end
            check("stall_busy", 64'(stall), 64'd1);
            if (k >= 1) begin
                a = $urandom;
                b = $urandom;
                sgn = 1'($urandom_range(0, 1));
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no ready expected ready within %0d cycles", bound);
        end else begin
            check("stall_ready", 64'(stall), 64'd0);
        end
    endtask

    task automatic finish_div(input int hold);
        repeat (hold) @(negedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("end_after_drop", 64'(ready), 64'd1);
        check("stall_after_drop", 64'(stall), 64'd0);
        @(negedge clk);
        check("free_after_drop", 64'(ready), 64'd0);
        check("free_state", 64'(dbg_state), 64'(DivFree));
    endtask

    task automatic run_div(input logic [W-1:0] op1, input logic [W-1:0] op2, input logic s,
                           input logic [2*W-1:0] exp, input int lat);
        @(posedge clk);
        #1 issue(op1, op2, s, exp, lat);
        wait_ready(60);
        finish_div(2);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_state", 64'(dbg_state), 64'(DivFree));

        // first request issued as reset releases
        @(posedge clk);
        #1 rst = 1'b0;
        issue(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, W + 1);
        wait_ready(60);
        finish_div(5);

        run_div(32'hFFFFFFF9, 32'd2,        1'b1, 64'hFFFFFFFF_FFFFFFFD, W + 1);
        run_div(32'd5,        32'd0,        1'b0, 64'h0,                 2);
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, W + 1);
        run_div(32'd7,        32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, W + 1);
        run_div(32'hFFFFFFFF, 32'h10,       1'b0, 64'h0000000F_0FFFFFFF, W + 1);
        run_div(32'hFFFFFFF8, 32'd0,        1'b1, 64'h0,                 2);
        run_div(32'd3,        32'd5,        1'b0, 64'h00000003_00000000, W + 1);
        run_div(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 64'hFFFFFFFE_0000000E, W + 1);

        // annul while idle blocks acceptance
        @(posedge clk);
        #1 begin start = 1'b1; annul = 1'b1; a = 32'd5; b = 32'd1; sgn = 1'b0; end
        repeat (3) begin
            @(negedge clk);
            check("annul_free_stall", 64'(stall), 64'd0);
            check("annul_free_state", 64'(dbg_state), 64'(DivFree));
        end
        @(posedge clk);
        #1 begin start = 1'b0; annul = 1'b0; end

        // annul in the divide-by-zero state
        @(posedge clk);
        #1 begin start = 1'b1; a = 32'd5; b = 32'd0; sgn = 1'b0; end
        @(posedge clk);
        #1 annul = 1'b1;
        @(negedge clk);
        check("byzero_state", 64'(dbg_state), 64'(DivByZero));
        @(posedge clk);
        #1 begin annul = 1'b0; start = 1'b0; end
        repeat (3) begin
            @(negedge clk);
            check("annul_byzero_state", 64'(dbg_state), 64'(DivFree));
        end

        // annul at cnt=10, then a fresh divide
        @(posedge clk);
        #1 begin start = 1'b1; a = 32'd100; b = 32'd7; sgn = 1'b0; end
        repeat (11) @(posedge clk);
        #1 annul = 1'b1;
        @(negedge clk);
        check("annul_on_state", 64'(dbg_state), 64'(DivOn));
        check("annul_on_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1 begin annul = 1'b0; start = 1'b0; end
        repeat (4) begin
            @(negedge clk);
            check("annul_on_free", 64'(dbg_state), 64'(DivFree));
        end
        run_div(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, W + 1);

        // reset at cnt=20, then a request on the first edge after reset
        @(posedge clk);
        #1 begin start = 1'b1; a = 32'd100; b = 32'd7; sgn = 1'b0; end
        repeat (21) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 begin
            rst = 1'b0;
            issue(32'd1000, 32'd10, 1'b0, 64'h00000000_00000064, W + 1);
        end
        @(negedge clk);
        check("rst_mid_state", 64'(dbg_state), 64'(DivFree));
        check("rst_mid_ready", 64'(ready), 64'd0);
        check("rst_mid_result", result, 64'd0);
        wait_ready(60);
        finish_div(5);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
